disp_src_arbiter: RTL

Shares the six-digit seven-segment display among several digit sources: time-of-day, alarm setting, stopwatch and similar. Source 0 is the default owner. Higher-indexed sources take the display on request, subject to a minimum hold time. The block also blanks selected digits on a blink cadence for "setting" modes. It sits between the clock-function cores and the tube scan driver, feeding that driver's `hex0..hex5` and `dp_in` inputs directly.

---
 rtl/disp_pkg.sv | 25 ++
 rtl/disp_src_arbiter_blink_gen.sv | 35 +++
 rtl/disp_src_arbiter.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/disp_pkg.sv
// Shared definitions for the display source arbiter: digit geometry,
// the blank code, the grant FSM state type and a priority helper.
package disp_pkg;

  localparam int DIGITS = 6;
  localparam int NIB_W  = 4;
  localparam logic [NIB_W-1:0] BLANK_CODE = 4'ha;

  typedef enum logic {
    S_DEF,
    S_OWN
  } state_t;

  // Highest set bit index of v; 0 when no bit above bit 0 is set.
  // Callers clear bit 0, so 0 reads as "no non-default request".
  function automatic logic [2:0] hi_idx(input logic [7:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (v[i]) r = 3'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/disp_src_arbiter_blink_gen.sv
// Blink cadence generator: phase_on toggles every DIV cycles.
// Ports: clk, rst_n (async low), restart (clear + phase ON), phase_on.
module blink_gen
  #(parameter int DIV = 25_000_000)
  (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic phase_on
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          r_phase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_phase <= 1'b1;
    end else if (restart) begin
      r_cnt   <= '0;
      r_phase <= 1'b1;
    end else if (r_cnt == LAST) begin
      r_cnt   <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_cnt   <= r_cnt + CW'(1);
    end
  end

  assign phase_on = r_phase;

endmodule

// File: rtl/disp_src_arbiter.sv
// Display source arbiter: grants the 6-digit display to one source,
// enforces a minimum hold, and blank-masks digits on a blink cadence.
// Ports: clk, rst_n (async low), req, src_hex, src_dp, src_blink in;
//        hex0..hex5, dp_out (registered), gnt (one-hot), cur_src out.
// Build option: DISP_ARB_BLINK_EN compiles in blink_gen and masking.
module disp_src_arbiter
  import disp_pkg::*;
  #(
  parameter int N_SRC     = 3,
  parameter int HOLD_CYC  = 50_000_000,
  parameter int BLINK_DIV = 25_000_000
  )(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_SRC-1:0]        req,
  input  logic [N_SRC*24-1:0]     src_hex,
  input  logic [N_SRC*6-1:0]      src_dp,
  input  logic [N_SRC*6-1:0]      src_blink,
  output logic [3:0]              hex0,
  output logic [3:0]              hex1,
  output logic [3:0]              hex2,
  output logic [3:0]              hex3,
  output logic [3:0]              hex4,
  output logic [3:0]              hex5,
  output logic [5:0]              dp_out,
  output logic [N_SRC-1:0]        gnt,
  output logic [$clog2(N_SRC)-1:0] cur_src
);

  localparam int CW = $clog2(N_SRC);
  localparam int HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [HW-1:0] HOLD_LD = HW'(HOLD_CYC - 1);
  localparam int DW = DIGITS * NIB_W;

  state_t            r_state, w_state_nx;
  logic [CW-1:0]     r_cur, w_cur_nx;
  logic [HW-1:0]     r_hold, w_hold_nx;
  logic [N_SRC-1:0]  r_gnt, w_gnt_nx;
  logic [DW-1:0]     r_hex, w_hex_nx;
  logic [DIGITS-1:0] r_dp, w_dp_nx;

  logic [7:0]        w_req_ext, w_low_ext;
  logic [CW-1:0]     w_hi, w_lo;
  logic              w_chg;
  logic [DW-1:0]     w_sel_hex;
  logic [DIGITS-1:0] w_sel_dp;
  logic [DIGITS-1:0] w_mask;

  // Request vectors with bit 0 cleared; w_low_ext keeps only
  // sources strictly below the current owner.
  always_comb begin
    w_req_ext = '0;
    w_low_ext = '0;
    for (int k = 1; k < N_SRC; k++) begin
      w_req_ext[k] = req[k];
      w_low_ext[k] = req[k] & (k < int'(r_cur));
    end
  end

  assign w_hi = CW'(hi_idx(w_req_ext));
  assign w_lo = CW'(hi_idx(w_low_ext));

  always_comb begin
    w_state_nx = r_state;
    w_cur_nx   = r_cur;
    w_hold_nx  = (r_hold == '0) ? '0 : r_hold - HW'(1);
    unique case (r_state)
      S_DEF: begin
        if (w_hi != '0) begin
          w_state_nx = S_OWN;
          w_cur_nx   = w_hi;
          w_hold_nx  = HOLD_LD;
        end
      end
      S_OWN: begin
        // Preemption is checked first so it beats a same-cycle expiry.
        if (w_hi > r_cur) begin
          w_cur_nx  = w_hi;
          w_hold_nx = HOLD_LD;
        end else if (r_hold == '0 && !req[r_cur]) begin
          if (w_lo != '0) begin
            w_cur_nx  = w_lo;
            w_hold_nx = HOLD_LD;
          end else begin
            w_state_nx = S_DEF;
            w_cur_nx   = '0;
            w_hold_nx  = '0;
          end
        end
      end
      default: begin
        w_state_nx = S_DEF;
        w_cur_nx   = '0;
        w_hold_nx  = '0;
      end
    endcase
  end

  assign w_chg = (w_cur_nx != r_cur);

  always_comb begin
    w_gnt_nx = '0;
    w_gnt_nx[w_cur_nx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_DEF;
      r_cur   <= '0;
      r_hold  <= '0;
      r_gnt   <= N_SRC'(1);
    end else begin
      r_state <= w_state_nx;
      r_cur   <= w_cur_nx;
      r_hold  <= w_hold_nx;
      r_gnt   <= w_gnt_nx;
    end
  end

  assign w_sel_hex = src_hex[int'(r_cur)*DW +: DW];
  assign w_sel_dp  = src_dp[int'(r_cur)*DIGITS +: DIGITS];

`ifdef DISP_ARB_BLINK_EN
  logic w_phase_on;

  blink_gen #(.DIV(BLINK_DIV)) u_blink (
    .clk      (clk),
    .rst_n    (rst_n),
    .restart  (w_chg),
    .phase_on (w_phase_on)
  );

  assign w_mask = w_phase_on ? '0
                : src_blink[int'(r_cur)*DIGITS +: DIGITS];
`else
  logic w_unused_blink;
  assign w_unused_blink = ^src_blink ^ w_chg;
  assign w_mask = '0;
`endif

  always_comb begin
    w_hex_nx = '0;
    w_dp_nx  = '0;
    for (int d = 0; d < DIGITS; d++) begin
      w_hex_nx[d*NIB_W +: NIB_W] = w_mask[d] ? BLANK_CODE
                                 : w_sel_hex[d*NIB_W +: NIB_W];
      w_dp_nx[d] = w_mask[d] | w_sel_dp[d];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hex <= {DIGITS{BLANK_CODE}};
      r_dp  <= '1;
    end else begin
      r_hex <= w_hex_nx;
      r_dp  <= w_dp_nx;
    end
  end

  assign hex0    = r_hex[3:0];
  assign hex1    = r_hex[7:4];
  assign hex2    = r_hex[11:8];
  assign hex3    = r_hex[15:12];
  assign hex4    = r_hex[19:16];
  assign hex5    = r_hex[23:20];
  assign dp_out  = r_dp;
  assign gnt     = r_gnt;
  assign cur_src = r_cur;

endmodule
